// File: rtl/aes_tcdm_pkg.sv
// aes_tcdm_pkg -- shared constants and types for the TCDM responder.
//   LFSR_SEED / LFSR_TAPS : stall-generator LFSR reset value and feedback taps
//   OOR_RDATA             : read data returned for out-of-range accesses
//   rsp_t                 : registered response (valid, port index, data)
package aes_tcdm_pkg;

  localparam logic [7:0]  LFSR_SEED = 8'hA5;
  // Fibonacci taps 8,6,5,4 -> bits 7,5,4,3
  localparam logic [7:0]  LFSR_TAPS = 8'hB8;
  localparam logic [31:0] OOR_RDATA = 32'h0000_0000;
  localparam int          PORT_W    = 8;

  typedef struct packed {
    logic              valid;
    logic [PORT_W-1:0] port;
    logic [31:0]       data;
  } rsp_t;

endpackage

// File: rtl/aes_tcdm_rr_arbiter.sv
// aes_tcdm_rr_arbiter -- combinational round-robin arbiter with registered pointer.
//   clk_i, rst_i : clock, async active-high reset (ptr -> 0)
//   req_i        : per-port request
//   en_i         : 0 suppresses all grants, pointer holds
//   gnt_o        : one-hot grant
//   idx_o        : index of granted port (0 when no grant)
module aes_tcdm_rr_arbiter #(
  parameter int MP = 2,
  parameter int IW = (MP > 1) ? $clog2(MP) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [MP-1:0] req_i,
  input  logic          en_i,
  output logic [MP-1:0] gnt_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          found;
  int            p;

  // Scan ports starting at ptr, wrapping mod MP; first requester wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    p     = 0;
    for (int i = 0; i < MP; i++) begin
      p = int'(ptr_q) + i;
      if (p >= MP) p = p - MP;
      if (en_i && !found && req_i[p]) begin
        found    = 1'b1;
        gnt_o[p] = 1'b1;
        idx_o    = IW'(p);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found) ptr_d = (idx_o == IW'(MP-1)) ? '0 : idx_o + IW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/aes_tcdm_responder.sv
// aes_tcdm_responder -- single-port word memory shared by MP TCDM slave ports.
//   clk_i, rst_i   : clock, async active-high reset
//   tcdm_req_i     : per-port request          tcdm_gnt_o     : same-cycle grant
//   tcdm_add_i     : per-port byte address     tcdm_wen_i     : 1 = read, 0 = write
//   tcdm_be_i      : per-port byte enables     tcdm_data_i    : per-port write data
//   tcdm_r_data_o  : per-port read data        tcdm_r_valid_o : per-port response strobe
//   err_o          : sticky out-of-range flag
// Optional feature: define AES_TCDM_STALL_EN to insert LFSR-driven stall cycles.
module aes_tcdm_responder
  import aes_tcdm_pkg::*;
#(
  parameter int          MP        = 2,
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [MP-1:0]        tcdm_req_i,
  output logic [MP-1:0]        tcdm_gnt_o,
  input  logic [MP-1:0][31:0]  tcdm_add_i,
  input  logic [MP-1:0]        tcdm_wen_i,
  input  logic [MP-1:0][3:0]   tcdm_be_i,
  input  logic [MP-1:0][31:0]  tcdm_data_i,
  output logic [MP-1:0][31:0]  tcdm_r_data_o,
  output logic [MP-1:0]        tcdm_r_valid_o,
  output logic                 err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = (MP > 1) ? $clog2(MP) : 1;

  logic          stall;
  logic [MP-1:0] gnt;
  logic [IW-1:0] gidx;
  logic          any_gnt;

`ifdef AES_TCDM_STALL_EN
  logic [7:0] lfsr_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  end
  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  // Reset gates the enable so grants are forced low while rst_i is high.
  aes_tcdm_rr_arbiter #(.MP(MP), .IW(IW)) u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (tcdm_req_i),
    .en_i  (!rst_i && !stall),
    .gnt_o (gnt),
    .idx_o (gidx)
  );

  assign tcdm_gnt_o = gnt;
  assign any_gnt    = |gnt;

  // Granted request fields
  logic [31:0]   add_g, wdata_g, off;
  logic [3:0]    be_g;
  logic          wen_g, oor;
  logic [AW-1:0] widx;

  assign add_g   = tcdm_add_i[gidx];
  assign wdata_g = tcdm_data_i[gidx];
  assign be_g    = tcdm_be_i[gidx];
  assign wen_g   = tcdm_wen_i[gidx];
  assign off     = add_g - BASE_ADDR;
  // Below base wraps the subtraction, so check it explicitly.
  assign oor     = (add_g < BASE_ADDR) || ((off >> (AW + 2)) != 32'd0);
  assign widx    = off[AW+1:2];

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (any_gnt && !wen_g && !oor) begin
      for (int b = 0; b < 4; b++)
        if (be_g[b]) mem[widx][8*b +: 8] <= wdata_g[8*b +: 8];
    end
  end

  rsp_t rsp_q, rsp_d;
  logic err_q, err_d;

  always_comb begin
    rsp_d       = '0;
    rsp_d.valid = any_gnt;
    rsp_d.port  = PORT_W'(gidx);
    if (any_gnt && wen_g) rsp_d.data = oor ? OOR_RDATA : mem[widx];
    err_d = err_q | (any_gnt & oor);
  end

  // Async reset clears any pending response so nothing appears after release.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_q <= '0;
      err_q <= 1'b0;
    end else begin
      rsp_q <= rsp_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    tcdm_r_valid_o = '0;
    tcdm_r_data_o  = '0;
    for (int k = 0; k < MP; k++) begin
      if (rsp_q.valid && rsp_q.port == PORT_W'(k)) begin
        tcdm_r_valid_o[k] = 1'b1;
        tcdm_r_data_o[k]  = rsp_q.data;
      end
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_aes_tcdm_responder.sv
module tb_aes_tcdm_responder;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       req = '0;
  logic [1:0]       gnt;
  logic [1:0][31:0] add = '0;
  logic [1:0]       wen = '1;
  logic [1:0][3:0]  be = '0;
  logic [1:0][31:0] wdata = '0;
  logic [1:0][31:0] rdata;
  logic [1:0]       rvalid;
  logic             err;

  aes_tcdm_responder #(.MP(2), .DEPTH(1024), .BASE_ADDR(32'h0)) dut (
    .clk_i(clk), .rst_i(rst),
    .tcdm_req_i(req), .tcdm_gnt_o(gnt), .tcdm_add_i(add), .tcdm_wen_i(wen),
    .tcdm_be_i(be), .tcdm_data_i(wdata), .tcdm_r_data_o(rdata),
    .tcdm_r_valid_o(rvalid), .err_o(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          port;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sbq[$];

  // Staged per-port fields, applied to the DUT at the next step
  logic [1:0]       s_wen = '1;
  logic [1:0][31:0] s_add = '0;
  logic [1:0][3:0]  s_be = '0;
  logic [1:0][31:0] s_dat = '0;

  task automatic set_port(input int p, input logic w, input logic [31:0] a,
                          input logic [3:0] b, input logic [31:0] d);
    s_wen[p] = w; s_add[p] = a; s_be[p] = b; s_dat[p] = d;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive staged fields + req, check same-cycle grant, queue response.
  task automatic step(input string name, input logic [1:0] r, input logic [1:0] eg,
                      input logic [31:0] ed, input bit push = 1'b1);
    exp_t e;
    @(negedge clk);
    req = r; wen = s_wen; add = s_add; be = s_be; wdata = s_dat;
    #1;
    check({name, "_gnt"}, 32'(gnt), 32'(eg));
    if (eg != 2'b00 && push) begin
      e.port = eg[1] ? 1 : 0;
      e.data = ed;
      e.due  = cyc + 1;
      sbq.push_back(e);
    end
  endtask

  // Monitor: response must appear exactly one cycle after its grant, one-hot,
  // with zero data on the silent port; any other r_valid is unexpected.
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      n_cmp++;
      if (rvalid !== (2'b01 << e.port) || rdata[e.port] !== e.data ||
          rdata[1-e.port] !== 32'h0) begin
        n_bad++;
        $display("FAIL rsp@%0d: valid=%b data0=%h data1=%h expected port %0d data %h",
                 cyc, rvalid, rdata[0], rdata[1], e.port, e.data);
      end
    end else if (rvalid !== 2'b00) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_rvalid@%0d: valid=%b expected 00", cyc, rvalid);
    end
  end

  initial begin
    // Reset state with requests asserted
    req = 2'b11;
    repeat (2) @(negedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_rdata", rdata[0] | rdata[1], 32'h0);
    @(negedge clk);
    rst = 1'b0; req = 2'b00;

    // Two continuous requesters alternate 0,1,0,1,0,1 (writes answer with 0)
    set_port(0, 1'b0, 32'h100, 4'hF, 32'h0000_AAAA);
    set_port(1, 1'b0, 32'h104, 4'hF, 32'h0000_BBBB);
    for (int i = 0; i < 6; i++)
      step("rr", 2'b11, (i % 2 == 0) ? 2'b01 : 2'b10, 32'h0);

    // Full-word write then read-back on port 0, back to back
    set_port(0, 1'b0, 32'h10, 4'hF, 32'hCAFE_F00D);
    step("wr10", 2'b01, 2'b01, 32'h0);
    set_port(0, 1'b1, 32'h10, 4'h0, 32'h0);
    step("rd10", 2'b01, 2'b01, 32'hCAFE_F00D);

    // Port 1 alone, consecutive grants, reading the round-robin writes
    set_port(1, 1'b1, 32'h100, 4'h0, 32'h0);
    step("rd100", 2'b10, 2'b10, 32'h0000_AAAA);
    set_port(1, 1'b1, 32'h107, 4'h0, 32'h0);  // low address bits ignored
    step("rd104", 2'b10, 2'b10, 32'h0000_BBBB);

    // Partial byte-enable write
    set_port(0, 1'b0, 32'h20, 4'hF, 32'h1111_1111);
    step("wr20", 2'b01, 2'b01, 32'h0);
    set_port(0, 1'b0, 32'h20, 4'b0101, 32'hAABB_CCDD);
    step("wr20be", 2'b01, 2'b01, 32'h0);
    set_port(0, 1'b1, 32'h20, 4'h0, 32'h0);
    step("rd20", 2'b01, 2'b01, 32'h11BB_11DD);

    // Out of range: word index aliases word 0, which must be unaffected
    set_port(0, 1'b0, 32'h0, 4'hF, 32'h1234_5678);
    step("wr0", 2'b01, 2'b01, 32'h0);
    check("err_pre", 32'(err), 32'h0);
    set_port(0, 1'b1, 32'h1000, 4'h0, 32'h0);
    step("rd_oor", 2'b01, 2'b01, 32'h0);
    set_port(0, 1'b0, 32'h1000, 4'hF, 32'hDEAD_BEEF);
    step("wr_oor", 2'b01, 2'b01, 32'h0);
    check("err_set", 32'(err), 32'h1);
    set_port(0, 1'b1, 32'h0, 4'h0, 32'h0);
    step("rd0", 2'b01, 2'b01, 32'h1234_5678);
    step("idle", 2'b00, 2'b00, 32'h0);
    check("err_held", 32'(err), 32'h1);

    // Reset right after a granted read (ptr is 1 here): response dropped
    set_port(0, 1'b1, 32'h10, 4'h0, 32'h0);
    step("rd_drop", 2'b01, 2'b01, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1; req = 2'b00;
    repeat (2) @(negedge clk);
    #1;
    check("rst2_err", 32'(err), 32'h0);
    check("rst2_rvalid", 32'(rvalid), 32'h0);
    rst = 1'b0;

    // ptr back at 0: both requesting -> port 0 first, then port 1
    set_port(0, 1'b1, 32'h10, 4'h0, 32'h0);
    set_port(1, 1'b1, 32'h104, 4'h0, 32'h0);
    step("post_rst0", 2'b11, 2'b01, 32'hCAFE_F00D);
    step("post_rst1", 2'b11, 2'b10, 32'h0000_BBBB);
    step("idle2", 2'b00, 2'b00, 32'h0);
    check("err_after_rst", 32'(err), 32'h0);

    repeat (3) @(negedge clk);
    #1;
    check("sb_drained", 32'(sbq.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard bound on simulation length
  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete within 20000 time units");
    $fatal(1);
  end

endmodule
